// File: rtl/rijndael_shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows / bypass for 4, 6 or 8 column states.
// Valid/ready stages carry data, tag and mode; the permutation sits in front of the output stage.
module rijndael_shift_rows_pipe #(
  parameter int NB     = 4,
  parameter int TAG_W  = 4,
  parameter int IN_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [32*NB-1:0]     in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [32*NB-1:0]     out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [1:0]           out_mode
);

  localparam int W = 32 * NB;
  localparam logic [1:0] MODE_FWD = 2'b00;
  localparam logic [1:0] MODE_INV = 2'b01;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("rijndael_shift_rows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // 256-bit Rijndael moves rows 2 and 3 further than the 128/192-bit variants.
  function automatic int row_shift(input int row);
    case (row)
      0:       return 0;
      1:       return 1;
      2:       return (NB == 8) ? 3 : 2;
      default: return (NB == 8) ? 4 : 3;
    endcase
  endfunction

  function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic [1:0] mode);
    logic [W-1:0] r;
    int           src;
    r = d;
    for (int c = 0; c < NB; c++) begin
      for (int row = 0; row < 4; row++) begin
        if (mode == MODE_FWD) src = (c + row_shift(row)) % NB;
        else                  src = (c + NB - row_shift(row)) % NB;
        if (mode == MODE_FWD || mode == MODE_INV)
          r[W-1-8*(4*c+row) -: 8] = d[W-1-8*(4*src+row) -: 8];
      end
    end
    return r;
  endfunction

  logic             out_stage_ready;
  logic             p_valid;
  logic [W-1:0]     p_data;
  logic [TAG_W-1:0] p_tag;
  logic [1:0]       p_mode;

  assign out_stage_ready = !out_valid || out_ready;

  generate
    if (IN_REG != 0) begin : g_in_reg
      logic             a_valid;
      logic [W-1:0]     a_data;
      logic [TAG_W-1:0] a_tag;
      logic [1:0]       a_mode;

      assign in_ready = !a_valid || out_stage_ready;

      // NOTE: payload registers are reset too, so a mid-stall reset leaves no stale state visible.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_valid <= 1'b0;
          a_data  <= '0;
          a_tag   <= '0;
          a_mode  <= '0;
        end else if (in_ready) begin
          a_valid <= in_valid;
          if (in_valid) begin
            a_data <= in_data;
            a_tag  <= in_tag;
            a_mode <= in_mode;
          end
        end
      end

      assign p_valid = a_valid;
      assign p_data  = a_data;
      assign p_tag   = a_tag;
      assign p_mode  = a_mode;
    end else begin : g_no_in_reg
      assign in_ready = out_stage_ready;
      assign p_valid  = in_valid;
      assign p_data   = in_data;
      assign p_tag    = in_tag;
      assign p_mode   = in_mode;
    end
  endgenerate

  // NOTE: state is updated with non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_mode  <= '0;
    end else if (out_stage_ready) begin
      out_valid <= p_valid;
      if (p_valid) begin
        out_data <= shift_rows(p_data, p_mode);
        out_tag  <= p_tag;
        out_mode <= p_mode;
      end
    end
  end

endmodule

// File: tb/tb_rijndael_shift_rows_pipe.sv
// Bench for rijndael_shift_rows_pipe: four instances (NB=4 single stage, NB=4 two stage, NB=6, NB=8)
// fed the same stream and scored against a byte-matrix reference model.
module tb_rijndael_shift_rows_pipe;

  typedef struct packed {
    logic [3:0]   tag;
    logic [1:0]   mode;
    logic [255:0] data;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [1:0]   in_mode;
  logic [3:0]   in_tag;
  logic [255:0] in_data;
  logic         out_ready;
  logic [255:0] out_data [4];
  logic [3:0]   out_tag  [4];
  logic [1:0]   out_mode [4];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  txn_t         exp_q [4][$];
  logic [255:0] last_out [4];
  logic         burst;
  int           burst_first [4];
  int           burst_last  [4];
  int           burst_cnt   [4];

  function automatic int nb_of(input int k);
    return (k == 2) ? 6 : (k == 3) ? 8 : 4;
  endfunction

  // All states are top-aligned in 256 bits, so byte k always sits at [255-8k -: 8].
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      localparam int NBG = (g == 2) ? 6 : (g == 3) ? 8 : 4;
      localparam int W   = 32 * NBG;
      logic         rdy;
      logic         ov;
      logic [W-1:0] od;
      logic [3:0]   ot;
      logic [1:0]   om;

      rijndael_shift_rows_pipe #(
        .NB(NBG), .TAG_W(4), .IN_REG((g == 1) ? 1 : 0)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[g]), .in_ready(rdy), .in_mode(in_mode),
        .in_data(in_data[255 -: W]), .in_tag(in_tag),
        .out_valid(ov), .out_ready(out_ready), .out_data(od),
        .out_tag(ot), .out_mode(om)
      );

      assign in_ready[g] = rdy;
      assign out_valid[g] = ov;
      assign out_data[g] = 256'(od) << (256 - W);
      assign out_tag[g]  = ot;
      assign out_mode[g] = om;
    end
  endgenerate

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [263:0] got, input logic [263:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Forward gathers out[r][c] = in[r][(c+s) mod nb]; inverse scatters in[r][c] to out[r][(c+s) mod nb].
  function automatic logic [255:0] ref_model(input logic [255:0] d, input int nb, input logic [1:0] mode);
    logic [7:0]   m   [4][8];
    logic [7:0]   o   [4][8];
    int           s   [4];
    logic [255:0] r;
    s[0] = 0; s[1] = 1; s[2] = (nb == 8) ? 3 : 2; s[3] = (nb == 8) ? 4 : 3;
    for (int c = 0; c < nb; c++)
      for (int row = 0; row < 4; row++)
        m[row][c] = d[255-8*(4*c+row) -: 8];
    for (int c = 0; c < nb; c++)
      for (int row = 0; row < 4; row++) begin
        if (mode == 2'b00)      o[row][c] = m[row][(c + s[row]) % nb];
        else if (mode == 2'b01) o[row][(c + s[row]) % nb] = m[row][c];
        else                    o[row][c] = m[row][c];
      end
    r = '0;
    for (int c = 0; c < nb; c++)
      for (int row = 0; row < 4; row++)
        r[255-8*(4*c+row) -: 8] = o[row][c];
    return r;
  endfunction

  // Monitor: handshakes are decided on the negative edge, where inputs and outputs are settled.
  initial begin
    logic stall_prev [4];
    txn_t held [4];
    txn_t got;
    txn_t e;
    for (int k = 0; k < 4; k++) stall_prev[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        got = '{tag: out_tag[k], mode: out_mode[k], data: out_data[k]};
        if (!rst_n) begin
          stall_prev[k] = 1'b0;
        end else begin
          if (stall_prev[k]) check($sformatf("stall_hold_%0d", k), got, held[k]);
          if (out_valid[k] && out_ready) begin
            check($sformatf("sb_nonempty_%0d", k), 264'(exp_q[k].size() != 0), 264'(1));
            if (exp_q[k].size() != 0) begin
              e = exp_q[k].pop_front();
              check($sformatf("out_%0d", k), got, e);
            end
            last_out[k] = out_data[k];
            if (burst) begin
              if (burst_cnt[k] == 0) burst_first[k] = cyc;
              burst_last[k] = cyc;
              burst_cnt[k]++;
            end
          end
          stall_prev[k] = out_valid[k] && !out_ready;
          held[k] = got;
          if (in_valid[k] && in_ready[k])
            exp_q[k].push_back('{tag: in_tag, mode: in_mode, data: ref_model(in_data, nb_of(k), in_mode)});
        end
      end
    end
  end

  // Offers one state to all four instances and holds it until each has taken it.
  task automatic send(input logic [1:0] m, input logic [3:0] t, input logic [255:0] d);
    logic [3:0] done;
    int n;
    done = '0;
    n = 0;
    in_mode = m; in_tag = t; in_data = d; in_valid = 4'hf;
    while (done != 4'hf && n < 200) begin
      @(negedge clk);
      done = done | (in_valid & in_ready);
      @(posedge clk); #1;
      in_valid = ~done;
      n++;
    end
    check("send_accepted", 264'(done), 264'(4'hf));
    in_valid = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 264'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 264'(0));
  endtask

  function automatic logic [255:0] rand_state();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] d;
    rst_n = 1'b0; in_valid = '0; in_mode = '0; in_tag = '0; in_data = '0; out_ready = 1'b1;
    burst = 1'b0;
    for (int k = 0; k < 4; k++) begin burst_cnt[k] = 0; burst_first[k] = 0; burst_last[k] = 0; end

    #12;
    check("reset_out_valid", 264'(out_valid), 264'(0));
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_out_%0d", k), {out_tag[k], out_mode[k], out_data[k]}, 264'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", 264'(in_ready), 264'(4'hf));

    // Directed known-answer states: bytes 00..1f top-aligned.
    for (int k = 0; k < 32; k++) x[255-8*k -: 8] = 8'(k);
    send(2'b00, 4'd1, x);
    drain();
    check("pulse_out_valid", 264'(out_valid), 264'(0));
    check("kat_fwd_nb4", 264'(last_out[0][255 -: 128]), 264'(128'h00050a0f04090e03080d02070c01060b));
    check("kat_fwd_nb4_inreg", 264'(last_out[1][255 -: 128]), 264'(128'h00050a0f04090e03080d02070c01060b));
    check("kat_fwd_nb8_col0", 264'(last_out[3][255 -: 32]), 264'(32'h00050e13));
    check("kat_fwd_nb8_col7", 264'(last_out[3][31:0]), 264'(32'h1c010a0f));
    check("kat_fwd_nb6_col0", 264'(last_out[2][255 -: 32]), 264'(32'h00050a0f));
    check("kat_fwd_nb6_col5", 264'(last_out[2][95 -: 32]), 264'(32'h1401060b));

    send(2'b01, 4'd2, x);
    drain();
    check("kat_inv_nb4", 264'(last_out[0][255 -: 128]), 264'(128'h000d0a0704010e0b0805020f0c090603));

    y = {128'h00050a0f04090e03080d02070c01060b, 128'h0};
    send(2'b01, 4'd3, y);
    drain();
    check("inv_of_fwd_nb4", 264'(last_out[0][255 -: 128]), 264'(x[255 -: 128]));

    // Mode 11 behaves as bypass.
    for (int i = 0; i < 4; i++) begin
      d = rand_state();
      send(2'b11, 4'(i), d);
      drain();
      check("mode11_bypass_nb8", 264'(last_out[3]), 264'(d));
    end

    // Back-to-back burst of 16 with modes cycling 00/01/10.
    burst = 1'b1;
    for (int i = 0; i < 16; i++) send(2'(i % 3), 4'(i), rand_state());
    drain();
    burst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("burst_count_%0d", k), 264'(burst_cnt[k]), 264'(16));
      check($sformatf("burst_span_%0d", k), 264'(burst_last[k] - burst_first[k]), 264'(15));
    end

    // Five-cycle stall in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 30; i++) send(2'($urandom_range(0, 3)), 4'(i), rand_state());
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("stall_in_ready", 264'(in_ready), 264'(0));
        check("stall_fill_inreg", 264'(exp_q[1].size()), 264'(2));
        check("stall_fill_single", 264'(exp_q[0].size()), 264'(1));
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) send(2'($urandom_range(0, 3)), 4'($urandom), rand_state());
      end
      begin
        repeat (120) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while the pipelines are full and stalled.
    out_ready = 1'b0;
    in_data = rand_state(); in_mode = 2'b00; in_tag = 4'd5; in_valid = 4'hf;
    repeat (4) @(posedge clk);
    #1 in_valid = '0;
    check("full_in_ready", 264'(in_ready), 264'(0));
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 264'(out_valid), 264'(0));
    for (int k = 0; k < 4; k++)
      check($sformatf("async_rst_data_%0d", k), 264'(out_data[k]), 264'(0));
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 264'(in_ready), 264'(4'hf));
    d = rand_state();
    send(2'b01, 4'd9, d);
    drain();
    check("post_rst_inv_nb8", 264'(last_out[3]), 264'(ref_model(d, 8, 2'b01)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
